// File: rtl/fsm_1100_pkg.sv
// Shared definitions for the serial 1100 pattern detector: state type and
// the fixed state encoding.
package fsm_1100_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE = 2'b00;  // no useful prefix
    localparam logic [1:0] S1   = 2'b01;  // seen "1"
    localparam logic [1:0] S11  = 2'b10;  // seen "11" or a longer run of 1s
    localparam logic [1:0] S110 = 2'b11;  // seen "110"

endpackage

// File: rtl/fsm_1100_detector.sv
// Serial bit-stream detector for the sequence 1,1,0,0 (oldest first).
// Four-state Mealy FSM: the flag rises in the same cycle the final 0 is on
// bit_in, before the edge that consumes it.
module fsm_1100_detector
    import fsm_1100_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    output logic pattern_detected
);

    state_t state;
    state_t state_nxt;

    // State register; reset discards any partial match.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state function and Mealy detection flag.
    always_comb begin
        state_nxt        = IDLE;
        pattern_detected = 1'b0;
        case (state)
            IDLE: state_nxt = bit_in ? S1 : IDLE;
            S1:   state_nxt = bit_in ? S11 : IDLE;
            S11:  state_nxt = bit_in ? S11 : S110;
            S110: begin
                // No suffix of 1100 is a prefix of it, so a hit restarts
                // from IDLE; a 1 here keeps that 1 as a fresh prefix.
                state_nxt        = bit_in ? S1 : IDLE;
                pattern_detected = !bit_in && !rst;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsm_1100_detector.sv
// Self-checking bench for fsm_1100_detector: directed vector table followed
// by a random stream compared against a shift-register reference.
module tb_fsm_1100_detector;

    logic clk;
    logic rst;
    logic bit_in;
    logic pattern_detected;

    int checks;
    int failures;

    fsm_1100_detector dut (
        .clk              (clk),
        .rst              (rst),
        .bit_in           (bit_in),
        .pattern_detected (pattern_detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       b;
        logic [1:0] st;      // state expected while this vector is applied
        logic       det;     // flag expected while this vector is applied
        bit         chk_st;  // state is unknown before the first reset edge
    } vec_t;

    vec_t vecs[37];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic b, input logic [1:0] st,
                                input logic det, input bit chk);
        vec_t v;
        v.rst = r; v.b = b; v.st = st; v.det = det; v.chk_st = chk;
        return v;
    endfunction

    logic [2:0] hist;
    logic [1:0] exp_st;
    logic       exp_det;
    logic       b;
    bit         covered[8];
    int         ncov;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bit_in   = 1'b0;

        // Reset, two cycles with arbitrary data, then release with 0
        vecs[0]  = mk(1, 1, 2'b00, 0, 0);
        vecs[1]  = mk(1, 0, 2'b00, 0, 1);
        vecs[2]  = mk(0, 0, 2'b00, 0, 1);
        // Basic 1100
        vecs[3]  = mk(0, 1, 2'b00, 0, 1);
        vecs[4]  = mk(0, 1, 2'b01, 0, 1);
        vecs[5]  = mk(0, 0, 2'b10, 0, 1);
        vecs[6]  = mk(0, 0, 2'b11, 1, 1);
        // Long run then back-to-back: 1111001100
        vecs[7]  = mk(0, 1, 2'b00, 0, 1);
        vecs[8]  = mk(0, 1, 2'b01, 0, 1);
        vecs[9]  = mk(0, 1, 2'b10, 0, 1);
        vecs[10] = mk(0, 1, 2'b10, 0, 1);
        vecs[11] = mk(0, 0, 2'b10, 0, 1);
        vecs[12] = mk(0, 0, 2'b11, 1, 1);
        vecs[13] = mk(0, 1, 2'b00, 0, 1);
        vecs[14] = mk(0, 1, 2'b01, 0, 1);
        vecs[15] = mk(0, 0, 2'b10, 0, 1);
        vecs[16] = mk(0, 0, 2'b11, 1, 1);
        // Near miss 1101 keeps the trailing 1: 1101100
        vecs[17] = mk(0, 1, 2'b00, 0, 1);
        vecs[18] = mk(0, 1, 2'b01, 0, 1);
        vecs[19] = mk(0, 0, 2'b10, 0, 1);
        vecs[20] = mk(0, 1, 2'b11, 0, 1);
        vecs[21] = mk(0, 1, 2'b01, 0, 1);
        vecs[22] = mk(0, 0, 2'b10, 0, 1);
        vecs[23] = mk(0, 0, 2'b11, 1, 1);
        // 100 gives no pulse
        vecs[24] = mk(0, 1, 2'b00, 0, 1);
        vecs[25] = mk(0, 0, 2'b01, 0, 1);
        vecs[26] = mk(0, 0, 2'b00, 0, 1);
        vecs[27] = mk(0, 0, 2'b00, 0, 1);
        // Reset mid-pattern with S110 and bit 0: reset must mask the flag
        vecs[28] = mk(0, 1, 2'b00, 0, 1);
        vecs[29] = mk(0, 1, 2'b01, 0, 1);
        vecs[30] = mk(0, 0, 2'b10, 0, 1);
        vecs[31] = mk(1, 0, 2'b11, 0, 1);
        vecs[32] = mk(0, 1, 2'b00, 0, 1);
        vecs[33] = mk(0, 1, 2'b01, 0, 1);
        vecs[34] = mk(0, 0, 2'b10, 0, 1);
        vecs[35] = mk(0, 0, 2'b11, 1, 1);
        vecs[36] = mk(0, 0, 2'b00, 0, 1);

        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            rst    = vecs[i].rst;
            bit_in = vecs[i].b;
            #1;
            if (vecs[i].chk_st)
                check($sformatf("vec%0d_state", i), dut.state, vecs[i].st);
            check($sformatf("vec%0d_det", i), {1'b0, pattern_detected}, {1'b0, vecs[i].det});
        end

        // Random stream against a history-based reference; state is in IDLE here
        hist = 3'b000;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            b      = 1'($urandom_range(0, 1));
            rst    = 1'b0;
            bit_in = b;
            #1;
            exp_det = ({hist, b} == 4'b1100);
            if (hist == 3'b110)          exp_st = 2'b11;
            else if (hist[1:0] == 2'b11) exp_st = 2'b10;
            else if (hist[0])            exp_st = 2'b01;
            else                         exp_st = 2'b00;
            check("rand_state", dut.state, exp_st);
            check("rand_det", {1'b0, pattern_detected}, {1'b0, exp_det});
            covered[{exp_st, b}] = 1'b1;
            hist = {hist[1:0], b};
        end

        ncov = 0;
        for (int k = 0; k < 8; k++) if (covered[k]) ncov++;
        check("arc_coverage", 2'(ncov == 8), 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_1100_detector.md
# fsm_1100_detector

Serial bit-stream pattern detector that asserts a flag whenever the four most recent input bits form the sequence 1, 1, 0, 0 (oldest first). It is a small four-state Mealy FSM. It consumes one bit per clock and sits directly on a single-bit serial data path, feeding downstream control logic that reacts to the detection flag.

## Interface
- Parameters: none. The pattern and the state encoding are fixed.
- clk  input  1  sole clock; all state updates occur on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- bit_in  input  1  serial data bit; one bit is consumed per rising edge.
- pattern_detected  output  1  Mealy detection flag; high while the current bit completes 1100.
- One clock; reset is synchronous and active-high.

## Operation
- The internal state register is named `state`. It is 2 bits wide, and verification probes it hierarchically. Encoding:
  - IDLE = 2'b00: no useful prefix.
  - S1 = 2'b01: seen "1".
  - S11 = 2'b10: seen "11" (or longer run of 1s).
  - S110 = 2'b11: seen "110".
- Next-state function, as (state, bit_in) -> next state:
  - IDLE: 1 -> S1; 0 -> IDLE.
  - S1: 1 -> S11; 0 -> IDLE.
  - S11: 1 -> S11; 0 -> S110.
  - S110: 1 -> S1; 0 -> IDLE. The 0 case is a detection.
- pattern_detected = (state == S110) && (bit_in == 0) && !rst. It is purely combinational, with no register on the output.
- Overlap: after a detection the FSM returns to IDLE. This is correct because no suffix of 1100 is a prefix of 1100. Consecutive patterns such as 11001100 are each detected.
- A run of 1s of any length followed by 00 is detected. For example, 111100 flags on the final 0.
- 1101 aborts the pattern but keeps the trailing 1 as a prefix (S110 -> S1).
- Undefined or X input has no defined behaviour. No recovery logic is required beyond reset.

## Timing
- Reset: when rst = 1 at a rising edge, state becomes IDLE on that edge, overriding bit_in. While rst is high, pattern_detected = 0.
- The flag goes high in the same cycle the fourth bit (the final 0) is presented on bit_in, i.e. before the edge that consumes it. That edge then moves state to IDLE.
- Latency: zero cycles from the final bit to the flag. The flag is high for exactly one cycle per detection if bit_in is stable per cycle.
- Reset mid-sequence: any partial match is discarded. Matching restarts from IDLE on the first cycle after rst deasserts.
- Unreset power-up state is don't-care. A reset pulse is required before use.
- No handshake, no enable; every clock edge consumes a bit.

## Structure
- Shared package fsm_1100_pkg holds:
  - the 2-bit state type;
  - the constants IDLE, S1, S11, S110 with the exact encodings above.
- Single module containing:
  - one always_ff for the state register with synchronous reset;
  - one always_comb for next state and output.
- No sub-modules are warranted.

## Test plan
- Reset: hold rst = 1 for 2 cycles with random bit_in -> state == 2'b00 and pattern_detected == 0 throughout. After release with bit_in = 0, state stays 2'b00.
- Basic match: after reset drive 1,1,0,0 -> states 01, 10, 11. pattern_detected = 1 only while the final 0 is applied, then state returns to 00.
- Long run and back-to-back: drive 1,1,1,1,0,0,1,1,0,0 -> exactly two one-cycle pulses, on the 6th and 10th bits.
- Near misses: drive 1,1,0,1,1,0,0 -> state goes 11 -> 01 on the 4th bit; a single pulse occurs on the 7th bit. Driving 1,0,0 gives no pulse.
- Reset mid-pattern: drive 1,1,0, then assert rst for one cycle while bit_in = 0 -> no pulse, state 00. Then drive 1,1,0,0 -> pulse on the 4th bit.
- Exhaustive transition check: random 10k-bit stream with a reference shift-register model -> pattern_detected equals (last four bits == 1100) every cycle, and all 8 state/input arcs are covered.
